// File: rtl/packet_generator.sv
// packet_generator: per-node synthetic traffic source for a network simulator.
// While the simulator is RUNNING, an 8-bit LFSR is compared against INJ_RATE each cycle to
// decide whether to inject a packet. Each injected packet is stamped with current_cycle and
// a round-robin destination, then pushed into a small FIFO. When the simulator reports
// COMPLETED, the FIFO drains and done is raised.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   sim_state        simulator state (00 INVALID, 01 INITIALIZED, 10 RUNNING, 11 COMPLETED)
//   current_cycle    simulator cycle count, used as the packet timestamp
//   pkt_valid/ready  FIFO head handshake
//   pkt_src          this node's id (constant)
//   pkt_dest         destination of the head packet (0 when the queue is empty)
//   pkt_timestamp    generation cycle of the head packet (0 when the queue is empty)
//   num_generated    saturating count of enqueued packets
//   num_dropped      saturating count of packets lost to a full queue
//   done             generation finished and queue drained
module packet_generator #(
    parameter int unsigned CYCLE_WIDTH = 32,
    parameter int unsigned NODE_WIDTH  = 4,
    parameter int unsigned NUM_NODES   = 16,
    parameter int unsigned NODE_ID     = 0,
    parameter logic [8:0]  INJ_RATE    = 9'd16,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             sim_state,
    input  logic [CYCLE_WIDTH-1:0] current_cycle,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic [NODE_WIDTH-1:0]  pkt_src,
    output logic [NODE_WIDTH-1:0]  pkt_dest,
    output logic [CYCLE_WIDTH-1:0] pkt_timestamp,
    output logic [CYCLE_WIDTH-1:0] num_generated,
    output logic [CYCLE_WIDTH-1:0] num_dropped,
    output logic                   done
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [1:0] SIM_INVALID   = 2'b00;
    localparam logic [1:0] SIM_RUNNING   = 2'b10;
    localparam logic [1:0] SIM_COMPLETED = 2'b11;

    localparam logic [NODE_WIDTH-1:0] OWN_ID    = NODE_WIDTH'(NODE_ID);
    localparam logic [NODE_WIDTH-1:0] DEST_INIT = NODE_WIDTH'((NODE_ID + 1) % NUM_NODES);
    localparam logic [NODE_WIDTH:0]   NODES_W   = (NODE_WIDTH + 1)'(NUM_NODES);
    localparam logic [NODE_WIDTH:0]   OWN_ID_W  = (NODE_WIDTH + 1)'(NODE_ID);
    localparam logic [NODE_WIDTH:0]   ONE_W     = (NODE_WIDTH + 1)'(1);
    localparam logic [PTR_W:0]        DEPTH_CNT = (PTR_W + 1)'(QUEUE_DEPTH);
    localparam logic [PTR_W:0]        CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
    localparam logic [CYCLE_WIDTH-1:0] CYC_ONE  = CYCLE_WIDTH'(1);

    // Next destination: increment modulo NUM_NODES, skipping our own id.
    function automatic logic [NODE_WIDTH-1:0] step_dest(input logic [NODE_WIDTH-1:0] d);
        logic [NODE_WIDTH:0] n;
        n = {1'b0, d} + ONE_W;
        if (n >= NODES_W) n = '0;
        if (n == OWN_ID_W) begin
            n = n + ONE_W;
            if (n >= NODES_W) n = '0;
        end
        return n[NODE_WIDTH-1:0];
    endfunction

    logic [1:0]             state_q, state_d;
    logic [7:0]             lfsr_q, lfsr_d;
    logic [NODE_WIDTH-1:0]  dest_q, dest_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         count_q, count_d;
    logic [CYCLE_WIDTH-1:0] num_gen_q, num_gen_d, num_drop_q, num_drop_d;

    logic [NODE_WIDTH-1:0]  dest_mem [QUEUE_DEPTH];
    logic [CYCLE_WIDTH-1:0] ts_mem   [QUEUE_DEPTH];

    logic flush, active, gen, full, deq, enq, drop, lfsr_fb;

    assign flush   = (sim_state == SIM_INVALID);
    assign active  = (state_q == ACTIVE);
    // Decision uses the pre-advance LFSR value; INJ_RATE >= 256 always wins the compare.
    assign gen     = active && ({1'b0, lfsr_q} < INJ_RATE);
    assign full    = (count_q == DEPTH_CNT);
    assign deq     = pkt_valid && pkt_ready;
    // A same-cycle dequeue frees the slot a full queue would otherwise refuse.
    assign enq     = gen && (!full || deq);
    assign drop    = gen && full && !deq;
    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_comb begin
        lfsr_d     = active ? {lfsr_q[6:0], lfsr_fb} : lfsr_q;
        dest_d     = gen ? step_dest(dest_q) : dest_q;
        wr_ptr_d   = enq ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = deq ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d    = count_q;
        if (enq && !deq) count_d = count_q + CNT_ONE;
        if (!enq && deq) count_d = count_q - CNT_ONE;
        num_gen_d  = (enq && num_gen_q != '1) ? num_gen_q + CYC_ONE : num_gen_q;
        num_drop_d = (drop && num_drop_q != '1) ? num_drop_q + CYC_ONE : num_drop_q;

        state_d = state_q;
        case (state_q)
            IDLE:    if (sim_state == SIM_RUNNING) state_d = ACTIVE;
            // Judge emptiness after this cycle's traffic so a last-cycle packet is not stranded.
            ACTIVE:  if (sim_state == SIM_COMPLETED) state_d = (count_d != '0) ? DRAIN : DONE;
            DRAIN:   if (count_d == '0) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d    = IDLE;
            lfsr_d     = LFSR_SEED;
            dest_d     = DEST_INIT;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            num_gen_d  = '0;
            num_drop_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            lfsr_q     <= LFSR_SEED;
            dest_q     <= DEST_INIT;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            num_gen_q  <= '0;
            num_drop_q <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            dest_q     <= dest_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            num_gen_q  <= num_gen_d;
            num_drop_q <= num_drop_d;
        end
    end

    // Storage needs no reset: entries are only visible through the count-gated head outputs.
    always_ff @(posedge clk) begin
        if (enq) begin
            dest_mem[wr_ptr_q] <= dest_q;
            ts_mem[wr_ptr_q]   <= current_cycle;
        end
    end

    assign pkt_valid     = (count_q != '0);
    assign pkt_src       = OWN_ID;
    assign pkt_dest      = pkt_valid ? dest_mem[rd_ptr_q] : '0;
    assign pkt_timestamp = pkt_valid ? ts_mem[rd_ptr_q] : '0;
    assign num_generated = num_gen_q;
    assign num_dropped   = num_drop_q;
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_packet_generator.sv
// Directed bench for packet_generator. Main instance: NODE_ID=2, NUM_NODES=4, INJ_RATE=256,
// QUEUE_DEPTH=4. Second instance shares all inputs and uses INJ_RATE=0.
module tb_packet_generator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  sim_state;
    logic [31:0] current_cycle;
    logic        pkt_ready;

    logic        pkt_valid, done;
    logic [3:0]  pkt_src, pkt_dest;
    logic [31:0] pkt_timestamp, num_generated, num_dropped;

    logic        z_valid, z_done;
    logic [3:0]  z_src, z_dest;
    logic [31:0] z_ts, z_gen, z_drop;

    int checks   = 0;
    int failures = 0;
    int c0       = 0;

    always #5 clk = ~clk;

    packet_generator #(
        .CYCLE_WIDTH(32), .NODE_WIDTH(4), .NUM_NODES(4), .NODE_ID(2),
        .INJ_RATE(9'd256), .QUEUE_DEPTH(4), .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sim_state(sim_state), .current_cycle(current_cycle),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_src(pkt_src), .pkt_dest(pkt_dest),
        .pkt_timestamp(pkt_timestamp), .num_generated(num_generated),
        .num_dropped(num_dropped), .done(done)
    );

    packet_generator #(
        .CYCLE_WIDTH(32), .NODE_WIDTH(4), .NUM_NODES(16), .NODE_ID(0),
        .INJ_RATE(9'd0), .QUEUE_DEPTH(4), .LFSR_SEED(8'hA5)
    ) dut_z (
        .clk(clk), .reset_n(reset_n), .sim_state(sim_state), .current_cycle(current_cycle),
        .pkt_valid(z_valid), .pkt_ready(pkt_ready), .pkt_src(z_src), .pkt_dest(z_dest),
        .pkt_timestamp(z_ts), .num_generated(z_gen), .num_dropped(z_drop), .done(z_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        current_cycle = current_cycle + 1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sim_state = 2'b00; pkt_ready = 1'b0; current_cycle = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pkt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", pkt_valid); end
        checks++; if (pkt_dest !== 4'd0) begin failures++; $display("FAIL reset_dest got=%0d exp=0", pkt_dest); end
        checks++; if (pkt_timestamp !== 32'd0) begin failures++; $display("FAIL reset_ts got=%0d exp=0", pkt_timestamp); end
        checks++; if (num_generated !== 32'd0) begin failures++; $display("FAIL reset_gen got=%0d exp=0", num_generated); end
        checks++; if (num_dropped !== 32'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", num_dropped); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (pkt_src !== 4'd2) begin failures++; $display("FAIL reset_src got=%0d exp=2", pkt_src); end
        checks++; if (z_src !== 4'd0) begin failures++; $display("FAIL reset_z_src got=%0d exp=0", z_src); end
        checks++; if ({z_valid, z_done, z_dest} !== 6'd0) begin failures++; $display("FAIL reset_z_head got=%0h exp=0", {z_valid, z_done, z_dest}); end
        checks++; if ({z_ts, z_gen, z_drop} !== 96'd0) begin failures++; $display("FAIL reset_z_cnt got=%0h exp=0", {z_ts, z_gen, z_drop}); end
        reset_n = 1'b1;
    endtask

    // One packet per cycle with a ready consumer; also walks the destination sequence.
    task automatic test_inject_all();
        logic [3:0] exp_dest [6];
        exp_dest = '{4'd3, 4'd0, 4'd1, 4'd3, 4'd0, 4'd1};
        current_cycle = 1; sim_state = 2'b10; pkt_ready = 1'b1;
        tick();
        checks++; if (pkt_valid !== 1'b0) begin failures++; $display("FAIL inj_first_valid got=%0b exp=0", pkt_valid); end
        tick();
        checks++; if (pkt_valid !== 1'b1) begin failures++; $display("FAIL inj_head_valid got=%0b exp=1", pkt_valid); end
        checks++; if (pkt_timestamp !== 32'd2) begin failures++; $display("FAIL inj_head_ts got=%0d exp=2", pkt_timestamp); end
        checks++; if (pkt_dest !== exp_dest[0]) begin failures++; $display("FAIL inj_dest0 got=%0d exp=%0d", pkt_dest, exp_dest[0]); end
        for (int i = 1; i < 6; i++) begin
            tick();
            checks++; if (pkt_timestamp !== current_cycle - 1) begin failures++; $display("FAIL inj_ts%0d got=%0d exp=%0d", i, pkt_timestamp, current_cycle - 1); end
            checks++; if (pkt_dest !== exp_dest[i]) begin failures++; $display("FAIL inj_dest%0d got=%0d exp=%0d", i, pkt_dest, exp_dest[i]); end
        end
        checks++; if (num_generated !== 32'd6) begin failures++; $display("FAIL inj_gen got=%0d exp=6", num_generated); end
        checks++; if (num_dropped !== 32'd0) begin failures++; $display("FAIL inj_drop got=%0d exp=0", num_dropped); end
    endtask

    task automatic test_flush();
        sim_state = 2'b00;
        tick();
        checks++; if (pkt_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", pkt_valid); end
        checks++; if (num_generated !== 32'd0) begin failures++; $display("FAIL flush_gen got=%0d exp=0", num_generated); end
    endtask

    task automatic test_full_drop();
        pkt_ready = 1'b0; sim_state = 2'b10;
        tick();
        c0 = int'(current_cycle);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 3) begin
                checks++; if (num_generated !== 32'd4 || num_dropped !== 32'd0) begin failures++; $display("FAIL drop_mid got=%0d/%0d exp=4/0", num_generated, num_dropped); end
            end
        end
        checks++; if (num_generated !== 32'd4) begin failures++; $display("FAIL drop_gen got=%0d exp=4", num_generated); end
        checks++; if (num_dropped !== 32'd6) begin failures++; $display("FAIL drop_cnt got=%0d exp=6", num_dropped); end
        checks++; if (pkt_timestamp !== 32'(c0)) begin failures++; $display("FAIL drop_head_ts got=%0d exp=%0d", pkt_timestamp, c0); end
        checks++; if (pkt_dest !== 4'd3) begin failures++; $display("FAIL drop_head_dest got=%0d exp=3", pkt_dest); end
    endtask

    // Full queue, generation and dequeue in the same cycle: the new packet is accepted.
    task automatic test_full_accept();
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
        checks++; if (num_generated !== 32'd5) begin failures++; $display("FAIL acc_gen got=%0d exp=5", num_generated); end
        checks++; if (num_dropped !== 32'd6) begin failures++; $display("FAIL acc_drop got=%0d exp=6", num_dropped); end
        checks++; if (pkt_timestamp !== 32'(c0 + 1)) begin failures++; $display("FAIL acc_head_ts got=%0d exp=%0d", pkt_timestamp, c0 + 1); end
        checks++; if (pkt_dest !== 4'd0) begin failures++; $display("FAIL acc_head_dest got=%0d exp=0", pkt_dest); end
    endtask

    task automatic test_drain();
        int c1;
        sim_state = 2'b00; pkt_ready = 1'b0;
        tick();
        sim_state = 2'b10;
        tick();
        c1 = int'(current_cycle);
        tick();
        tick();
        sim_state = 2'b11;
        tick();
        checks++; if (num_generated !== 32'd3) begin failures++; $display("FAIL drain_gen got=%0d exp=3", num_generated); end
        checks++; if (pkt_valid !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL drain_enter got=v%0b/d%0b exp=v1/d0", pkt_valid, done); end
        tick();
        checks++; if (num_generated !== 32'd3) begin failures++; $display("FAIL drain_nogen got=%0d exp=3", num_generated); end
        pkt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (pkt_timestamp !== 32'(c1 + i) || done !== 1'b0) begin failures++; $display("FAIL drain_hs%0d got=ts%0d/d%0b exp=ts%0d/d0", i, pkt_timestamp, done, c1 + i); end
            tick();
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL drain_done got=%0b exp=1", done); end
        checks++; if (pkt_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0b exp=0", pkt_valid); end
    endtask

    task automatic test_zero_rate_reset();
        int bad;
        bad = 0;
        sim_state = 2'b00; pkt_ready = 1'b0;
        tick();
        sim_state = 2'b10;
        tick();
        for (int i = 0; i < 100; i++) begin
            tick();
            if (z_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL zero_valid got=%0d_cycles_valid exp=0", bad); end
        checks++; if (z_gen !== 32'd0) begin failures++; $display("FAIL zero_gen got=%0d exp=0", z_gen); end
        checks++; if (pkt_valid !== 1'b1 || num_generated !== 32'd4) begin failures++; $display("FAIL pre_reset got=v%0b/g%0d exp=v1/g4", pkt_valid, num_generated); end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (pkt_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%0b exp=0", pkt_valid); end
        checks++; if (pkt_dest !== 4'd0 || pkt_timestamp !== 32'd0) begin failures++; $display("FAIL async_head got=%0d/%0d exp=0/0", pkt_dest, pkt_timestamp); end
        checks++; if (num_generated !== 32'd0 || num_dropped !== 32'd0) begin failures++; $display("FAIL async_cnt got=%0d/%0d exp=0/0", num_generated, num_dropped); end
        checks++; if (done !== 1'b0 || pkt_src !== 4'd2) begin failures++; $display("FAIL async_misc got=d%0b/s%0d exp=d0/s2", done, pkt_src); end
        sim_state = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_inject_all();
        test_flush();
        test_full_drop();
        test_full_accept();
        test_drain();
        test_zero_rate_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
